// File: rtl/pe_share_arbiter.sv
// pe_share_arbiter: shares one fixed-latency priority encoder between N_REQ
// requesters. Round-robin grants, a tag pipe that tracks which requester owns
// each word in the encoder, result steering, and a sticky latency-mismatch flag.
module pe_share_arbiter #(
    parameter int WIDTH   = 16,
    parameter int N_REQ   = 4,
    parameter int ENC_LAT = 1
) (
    input  logic                     clk_i,
    input  logic                     srst_n_i,
    input  logic                     arb_en_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*WIDTH-1:0]   req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [WIDTH-1:0]         enc_data_o,
    output logic                     enc_data_val_o,
    input  logic [WIDTH-1:0]         enc_left_i,
    input  logic [WIDTH-1:0]         enc_right_i,
    input  logic                     enc_data_val_i,
    output logic [N_REQ-1:0]         res_valid_o,
    output logic [WIDTH-1:0]         res_left_o,
    output logic [WIDTH-1:0]         res_right_o,
    output logic [3:0]               inflight_o,
    output logic                     err_o
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int SUM_W = PTR_W + 1;

    logic [PTR_W-1:0]   r_ptr;
    logic [N_REQ-1:0]   w_grant;
    logic [PTR_W-1:0]   w_gidx;
    logic [WIDTH-1:0]   w_gdata;
    logic               w_xfer;
    logic [SUM_W-1:0]   w_sum;

    logic               r_enc_val;
    logic [WIDTH-1:0]   r_enc_data;
    logic [3:0]         r_tag;

    logic [ENC_LAT-1:0] r_pv;
    logic [3:0]         r_pt [ENC_LAT];
    logic               w_pipe_v;
    logic [3:0]         w_pipe_tag;
    logic               w_match;
    logic [N_REQ-1:0]   w_onehot;

    logic [N_REQ-1:0]   r_res_valid;
    logic [WIDTH-1:0]   r_res_left;
    logic [WIDTH-1:0]   r_res_right;
    logic [3:0]         r_inflight;
    logic [3:0]         r_drain;
    logic               r_err;

    // Round-robin search starting at r_ptr, wrapping at N_REQ-1; first valid wins.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_gdata = '0;
        w_xfer  = 1'b0;
        w_sum   = '0;
        if (srst_n_i && arb_en_i) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_sum = {1'b0, r_ptr} + SUM_W'(k);
                if (w_sum >= SUM_W'(N_REQ)) begin
                    w_sum = w_sum - SUM_W'(N_REQ);
                end
                if (!w_xfer && req_valid_i[w_sum[PTR_W-1:0]]) begin
                    w_xfer                     = 1'b1;
                    w_gidx                     = w_sum[PTR_W-1:0];
                    w_grant[w_sum[PTR_W-1:0]]  = 1'b1;
                    w_gdata                    = req_data_i[w_sum[PTR_W-1:0]*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Register the granted word toward the encoder and advance the pointer past the winner.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_enc_val  <= 1'b0;
            r_enc_data <= '0;
            r_tag      <= '0;
            r_ptr      <= '0;
        end else begin
            r_enc_val <= w_xfer;
            if (w_xfer) begin
                r_enc_data <= w_gdata;
                r_tag      <= 4'(w_gidx);
                if (w_gidx == PTR_W'(N_REQ - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_gidx + PTR_W'(1);
                end
            end
        end
    end

    // Tag pipe mirrors the encoder latency so its tail lines up with enc_data_val_i.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_pv <= '0;
            for (int i = 0; i < ENC_LAT; i++) begin
                r_pt[i] <= '0;
            end
        end else begin
            r_pv[0] <= r_enc_val;
            r_pt[0] <= r_tag;
            for (int i = 1; i < ENC_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pt[i] <= r_pt[i-1];
            end
        end
    end

    assign w_pipe_v   = r_pv[ENC_LAT-1];
    assign w_pipe_tag = r_pt[ENC_LAT-1];
    assign w_match    = w_pipe_v & enc_data_val_i;
    assign w_onehot   = N_REQ'(1) << w_pipe_tag;

    // Steer a matched encoder result to its owner; buses keep their last value otherwise.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_res_valid <= '0;
            r_res_left  <= '0;
            r_res_right <= '0;
        end else begin
            r_res_valid <= w_match ? w_onehot : '0;
            if (w_match) begin
                r_res_left  <= enc_left_i;
                r_res_right <= enc_right_i;
            end
        end
    end

    // Words between the edge that raises enc_data_val_o and the edge that presents the result.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_inflight <= '0;
        end else if (w_xfer && !w_match) begin
            r_inflight <= r_inflight + 4'd1;
        end else if (!w_xfer && w_match && (r_inflight != 4'd0)) begin
            r_inflight <= r_inflight - 4'd1;
        end
    end

    // Sticky latency-mismatch flag; stray returns of discarded words are tolerated while draining.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_drain <= 4'(ENC_LAT + 1);
            r_err   <= 1'b0;
        end else begin
            if (r_drain != 4'd0) begin
                r_drain <= r_drain - 4'd1;
            end
            if ((enc_data_val_i && !w_pipe_v && (r_drain == 4'd0)) ||
                (w_pipe_v && !enc_data_val_i)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign req_ready_o    = w_grant;
    assign enc_data_o     = r_enc_data;
    assign enc_data_val_o = r_enc_val;
    assign res_valid_o    = r_res_valid;
    assign res_left_o     = r_res_left;
    assign res_right_o    = r_res_right;
    assign inflight_o     = r_inflight;
    assign err_o          = r_err;

endmodule
